spi_host_controller: RTL and testbench
======================================

// Module: spi_host_controller
// PURPOSE
// SPI initiator (mode 0, MSB first) that drives the rapcore SPI responder pins SCK/CS/COPI and samples CIPO.
// Used by the harness and bench to issue command/data words to rapcore, e.g. for move, config and status reads.
// It also gives an on-chip host path for Caravel GPIO bring-up.
// One word per CS frame; received word returned with a 1-cycle valid pulse.
// PARAMETERS
// WORD_W    64  bits per transfer; must match rapcore SPI word width
// CLK_DIV   4   CLK cycles per SCK half-period (>=1); SCK freq = CLK/(2*CLK_DIV)
// CS_SETUP  2   CLK cycles from CS low to first SCK rise window start (>=1)
// CS_HOLD   2   CLK cycles from last SCK fall to CS high (>=1)
// CS_IDLE   2   minimum CLK cycles CS stays high between frames (>=1)
// PORTS
// CLK       in   1       system clock; all logic on posedge
// resetn    in   1       synchronous, active-low reset
// tx_data   in   WORD_W  word to transmit; captured on tx_valid&&tx_ready
// tx_valid  in   1       request to start a frame
// tx_ready  out  1       controller can accept tx_data this cycle
// rx_data   out  WORD_W  last received word; stable until next rx_valid
// rx_valid  out  1       1-cycle pulse: rx_data updated, frame complete
// busy      out  1       high from accept cycle+1 until return to IDLE
// SCK       out  1       SPI clock, idles low
// CS        out  1       chip select, active low
// COPI      out  1       controller-out data
// CIPO      in   1       controller-in data, sampled on SCK rise
// BEHAVIOUR
// - Reset (resetn=0 at posedge): state=IDLE, CS=1, SCK=0, COPI=0, tx_ready=1, rx_valid=0, busy=0, rx_data=0, counters=0.
// - Reset mid-frame aborts the frame: partial word is discarded, no rx_valid pulse, CS=1 on the next cycle.
// - States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
// - IDLE: tx_ready=1. On tx_valid, latch tx_data into the shift reg (cycle T0) and go to SETUP.
// - tx_ready is low in all other states (see burst option).
// - SETUP: CS_SETUP cycles; CS=0, SCK=0, COPI=tx_data[WORD_W-1] from T1.
// - XFER: WORD_W bits. Each bit is CLK_DIV cycles SCK=0, then CLK_DIV cycles SCK=1.
// - XFER CIPO: sampled into the rx shift reg on the CLK edge that raises SCK.
// - XFER COPI: shifts to the next bit on the edge that lowers SCK. There is no shift after the last bit.
// - HOLD: CS_HOLD cycles; CS=0, SCK=0, COPI holds the last bit.
// - GAP entry (cycle T0+1+CS_SETUP+2*CLK_DIV*WORD_W+CS_HOLD): CS=1, COPI=0, rx_data<=rx shift reg, rx_valid=1 for exactly one cycle.
// - GAP: CS_IDLE cycles, then IDLE with tx_ready=1.
// - Accept-to-next-accept minimum = 1+CS_SETUP+2*CLK_DIV*WORD_W+CS_HOLD+CS_IDLE cycles.
// - SCK, CS and COPI are driven directly from flops; no combinational path from inputs to pins.
// - tx_valid while busy is ignored (no queueing). tx_data is don't-care except on the accept cycle.
// - The bit counter (clog2(WORD_W+1) bits) and half-period counter (clog2(CLK_DIV+1) bits) never wrap inside a frame.
// - Counters clear on state entry.
// CONFIGURATION
// SPI_HOST_BURST_EN defined:
// - tx_ready is also high during the final HOLD cycle.
// - Accept there: rx_valid pulses for the old word on the next cycle; CS stays low; GAP is skipped.
// - The next cycle enters SETUP with the new MSB on COPI, giving back-to-back words in one CS frame.
// - With no accept, behaviour is unchanged.
// SPI_HOST_BURST_EN undefined:
// - tx_ready only in IDLE; CS always deasserts >=CS_IDLE cycles between words.
// TESTING
// 1. Loopback COPI->CIPO, defaults, tx_data=64'hDEADBEEF_0123_4567.
//    -> rx_valid once at T0+1+2+512+2; rx_data=64'hDEADBEEF_0123_4567; exactly 64 SCK rises.
// 2. CIPO driven by a mode-0 responder model returning 64'hA5A5_0000_FFFF_1234; tx_data=0.
//    -> rx_data=64'hA5A5_0000_FFFF_1234; COPI=0 throughout CS low.
// 3. CLK_DIV=1, WORD_W=8, tx_data=8'h81.
//    -> SCK toggles every CLK; COPI sequence 1,0,0,0,0,0,0,1; CS low for 2+16+2 cycles.
// 4. resetn=0 for 1 cycle during bit 10 of XFER.
//    -> next cycle CS=1, SCK=0, tx_ready=1, no rx_valid; new request then completes normally.
// 5. tx_valid held high continuously, two words 64'h1 and 64'h2, burst macro undefined.
//    -> two CS frames separated by exactly 2 CS-high cycles in GAP plus 1 IDLE accept cycle.
// 6. As 5 with SPI_HOST_BURST_EN.
//    -> single CS-low period; 128 SCK rises; two rx_valid pulses; rx_data 64'h1 then 64'h2.

Source files
------------

// File: rtl/spi_host_controller.sv
// spi_host_controller: mode-0, MSB-first SPI initiator, one word per CS frame.
// Define SPI_HOST_BURST_EN to allow back-to-back words inside one CS frame.
module spi_host_controller #(
   parameter int WORD_W   = 64,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              CLK,
   input  logic              resetn,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              SCK,
   output logic              CS,
   output logic              COPI,
   input  logic              CIPO
);
`ifdef SPI_HOST_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam int HW   = $clog2(CLK_DIV + 1);
   localparam int BW   = $clog2(WORD_W + 1);
   localparam int WMAX = CS_SETUP > CS_HOLD ? (CS_SETUP > CS_IDLE ? CS_SETUP : CS_IDLE)
                                            : (CS_HOLD > CS_IDLE ? CS_HOLD : CS_IDLE);
   localparam int WW   = $clog2(WMAX + 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t            state, state_n;
   logic [HW-1:0]     hcnt;
   logic [BW-1:0]     bcnt;
   logic [WW-1:0]     wcnt;
   logic [WORD_W-1:0] tx_sr, rx_sr;
   logic              accept, half_end, hold_last, sample, shift, done, cs_d, sck_d;

   assign hold_last = state == HOLD && wcnt == WW'(CS_HOLD - 1);
   assign tx_ready  = state == IDLE || (BURST && hold_last);
   assign busy      = state != IDLE;
   assign accept    = tx_valid && tx_ready;
   assign half_end  = state == XFER && hcnt == HW'(CLK_DIV - 1);
   // COPI is the top of the tx shift register, so it is flop-driven
   assign COPI      = tx_sr[WORD_W-1];

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state    <= IDLE;
         hcnt     <= '0;
         bcnt     <= '0;
         wcnt     <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         CS       <= 1'b1;
         SCK      <= 1'b0;
      end else begin
         state    <= state_n;
         wcnt     <= state_n != state || state inside {IDLE, XFER} ? '0 : wcnt + 1'b1;
         hcnt     <= state != XFER || half_end ? '0 : hcnt + 1'b1;
         bcnt     <= state_n != state ? '0 : bcnt + BW'(shift);
         tx_sr    <= accept ? tx_data : shift ? {tx_sr[WORD_W-2:0], 1'b0} : done ? '0 : tx_sr;
         rx_sr    <= sample ? {rx_sr[WORD_W-2:0], CIPO} : rx_sr;
         rx_data  <= done ? rx_sr : rx_data;
         rx_valid <= done;
         CS       <= cs_d;
         SCK      <= sck_d;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = SETUP;
         SETUP:   if (wcnt == WW'(CS_SETUP - 1)) state_n = XFER;
         XFER:    if (half_end && SCK && bcnt == BW'(WORD_W - 1)) state_n = HOLD;
         HOLD:    if (hold_last) state_n = accept ? SETUP : GAP;
         GAP:     if (wcnt == WW'(CS_IDLE - 1)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Pin values are computed for the next state and registered
   always_comb begin
      sample = half_end && !SCK;
      shift  = half_end && SCK && state_n == XFER;
      done   = state == HOLD && state_n != HOLD;
      cs_d   = state_n == IDLE || state_n == GAP;
      sck_d  = state_n == XFER && (half_end ? !SCK : SCK);
   end
endmodule

// File: tb/tb_spi_host_controller.sv
// tb_spi_host_controller: directed bench for spi_host_controller (64-bit default
// instance with loopback/responder CIPO, plus an 8-bit CLK_DIV=1 loopback instance).
module tb_spi_host_controller;
   logic        CLK = 1'b0, resetn = 1'b0;
   logic [63:0] tx_data0 = '0, rx_data0, resp_word = '0;
   logic        tx_valid0 = 1'b0, tx_ready0, rx_valid0, busy0, SCK0, CS0, COPI0, CIPO0;
   logic        mode = 1'b0;
   logic [7:0]  tx_data1 = '0, rx_data1, seq1 = '0;
   logic        tx_valid1 = 1'b0, tx_ready1, rx_valid1, busy1, SCK1, CS1, COPI1;
   logic [6:0]  ridx = '0;
   logic [63:0] rxd_prev0 = '0, rxd_last0 = '0;
   int n_tests = 0, n_fail = 0;
   int cyc = 0, acc0 = 0, acc_cyc0 = 0, rxv0 = 0, rxv_cyc0 = 0, rise0 = 0, csl0 = 0;
   int copih0 = 0, csfall0 = 0, csgap0 = 0, last_gap0 = 0;
   int csl1 = 0, sckh1 = 0, rxv1 = 0, rise1 = 0;

   spi_host_controller dut0 (
      .CLK(CLK), .resetn(resetn), .tx_data(tx_data0), .tx_valid(tx_valid0),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
      .SCK(SCK0), .CS(CS0), .COPI(COPI0), .CIPO(CIPO0)
   );

   spi_host_controller #(.WORD_W(8), .CLK_DIV(1)) dut1 (
      .CLK(CLK), .resetn(resetn), .tx_data(tx_data1), .tx_valid(tx_valid1),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
      .SCK(SCK1), .CS(CS1), .COPI(COPI1), .CIPO(COPI1)
   );

   always #5 CLK = ~CLK;

   // Mode-0 responder: first bit valid at CS fall, next bit after each SCK fall
   assign CIPO0 = mode ? (!ridx[6] && resp_word[~ridx[5:0]]) : COPI0;
   always @(negedge SCK0 or posedge CS0) ridx = CS0 ? 7'd0 : ridx + 7'd1;

   always @(posedge SCK0) rise0++;

   always @(posedge CLK) begin
      cyc++;
      if (tx_valid0 && tx_ready0) begin
         acc0++;
         acc_cyc0 = cyc;
      end
      if (rx_valid0) begin
         rxv0++;
         rxv_cyc0  = cyc;
         rxd_prev0 = rxd_last0;
         rxd_last0 = rx_data0;
      end
      if (!CS0) begin
         csl0++;
         if (COPI0) copih0++;
         if (csgap0 > 0) begin
            last_gap0 = csgap0;
            csfall0++;
         end
         csgap0 = 0;
      end else csgap0++;
   end

   always @(posedge CLK) begin
      if (!CS1) csl1++;
      if (SCK1) sckh1++;
      if (rx_valid1) rxv1++;
   end

   always @(posedge SCK1) begin
      rise1++;
      seq1 = {seq1[6:0], COPI1};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b_rise, b_rxv, b_acc, b_fall, b_copi, b_csl, b_sckh, b_rise1, b_rxv1;
      resetn = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_cs", 64'(CS0), 64'd1);
      check("rst_sck", 64'(SCK0), 64'd0);
      check("rst_copi", 64'(COPI0), 64'd0);
      check("rst_ready", 64'(tx_ready0), 64'd1);
      check("rst_rxv", 64'(rx_valid0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_rxd", rx_data0, 64'd0);
      resetn = 1'b1;
      @(negedge CLK);

      // loopback, default timing
      b_rise = rise0; b_rxv = rxv0;
      tx_data0 = 64'hDEADBEEF_0123_4567; tx_valid0 = 1'b1;
      @(negedge CLK);
      tx_valid0 = 1'b0;
      check("t1_busy", 64'(busy0), 64'd1);
      check("t1_ready_low", 64'(tx_ready0), 64'd0);
      check("t1_cs_low", 64'(CS0), 64'd0);
      check("t1_copi_msb", 64'(COPI0), 64'd1);
      for (int i = 0; i < 2000 && rxv0 < b_rxv + 1; i++) @(negedge CLK);
      check("t1_rxv", 64'(rxv0 - b_rxv), 64'd1);
      check("t1_latency", 64'(rxv_cyc0 - acc_cyc0), 64'd517);
      check("t1_data", rx_data0, 64'hDEADBEEF_0123_4567);
      check("t1_rises", 64'(rise0 - b_rise), 64'd64);
      check("t1_pulse", 64'(rx_valid0), 64'd0);
      check("t1_cs_gap", 64'(CS0), 64'd1);
      repeat (4) @(negedge CLK);
      check("t1_idle", 64'(tx_ready0), 64'd1);

      // responder model, tx all zeros
      mode = 1'b1; resp_word = 64'hA5A5_0000_FFFF_1234;
      b_copi = copih0; b_rxv = rxv0; b_csl = csl0;
      tx_data0 = 64'd0; tx_valid0 = 1'b1;
      @(negedge CLK);
      tx_valid0 = 1'b0;
      for (int i = 0; i < 2000 && rxv0 < b_rxv + 1; i++) @(negedge CLK);
      check("t2_rxv", 64'(rxv0 - b_rxv), 64'd1);
      check("t2_data", rx_data0, 64'hA5A5_0000_FFFF_1234);
      check("t2_copi_zero", 64'(copih0 - b_copi), 64'd0);
      check("t2_cs_low", 64'(csl0 - b_csl), 64'd516);
      repeat (4) @(negedge CLK);
      mode = 1'b0;

      // 8-bit, CLK_DIV=1 instance
      b_csl = csl1; b_sckh = sckh1; b_rise1 = rise1; b_rxv1 = rxv1;
      tx_data1 = 8'h81; tx_valid1 = 1'b1;
      @(negedge CLK);
      tx_valid1 = 1'b0;
      for (int i = 0; i < 100 && rxv1 < b_rxv1 + 1; i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      check("t3_rxv", 64'(rxv1 - b_rxv1), 64'd1);
      check("t3_cs_low", 64'(csl1 - b_csl), 64'd20);
      check("t3_rises", 64'(rise1 - b_rise1), 64'd8);
      check("t3_sck_high", 64'(sckh1 - b_sckh), 64'd8);
      check("t3_copi_seq", 64'(seq1), 64'h81);
      check("t3_data", 64'(rx_data1), 64'h81);

      // reset in the middle of bit 10
      b_rise = rise0; b_rxv = rxv0;
      tx_data0 = 64'hFFFF_0000_FFFF_0000; tx_valid0 = 1'b1;
      @(negedge CLK);
      tx_valid0 = 1'b0;
      for (int i = 0; i < 1000 && rise0 < b_rise + 11; i++) @(negedge CLK);
      check("t4_reach_bit10", 64'(rise0 - b_rise), 64'd11);
      resetn = 1'b0;
      @(negedge CLK);
      resetn = 1'b1;
      check("t4_cs", 64'(CS0), 64'd1);
      check("t4_sck", 64'(SCK0), 64'd0);
      check("t4_copi", 64'(COPI0), 64'd0);
      check("t4_ready", 64'(tx_ready0), 64'd1);
      check("t4_busy", 64'(busy0), 64'd0);
      repeat (600) @(negedge CLK);
      check("t4_no_rxv", 64'(rxv0 - b_rxv), 64'd0);
      tx_data0 = 64'h0123_4567_89AB_CDEF; tx_valid0 = 1'b1;
      @(negedge CLK);
      tx_valid0 = 1'b0;
      for (int i = 0; i < 2000 && rxv0 < b_rxv + 1; i++) @(negedge CLK);
      check("t4_rxv", 64'(rxv0 - b_rxv), 64'd1);
      check("t4_data", rx_data0, 64'h0123_4567_89AB_CDEF);
      repeat (4) @(negedge CLK);

      // tx_valid held high across two words
      b_rise = rise0; b_rxv = rxv0; b_acc = acc0; b_fall = csfall0;
      tx_data0 = 64'h1; tx_valid0 = 1'b1;
      for (int i = 0; i < 10 && acc0 == b_acc; i++) @(negedge CLK);
      tx_data0 = 64'h2;
      for (int i = 0; i < 2000 && acc0 < b_acc + 2; i++) @(negedge CLK);
      tx_valid0 = 1'b0;
      check("t5_accepts", 64'(acc0 - b_acc), 64'd2);
      for (int i = 0; i < 2000 && rxv0 < b_rxv + 2; i++) @(negedge CLK);
      check("t5_rxv", 64'(rxv0 - b_rxv), 64'd2);
      check("t5_first", rxd_prev0, 64'h1);
      check("t5_second", rxd_last0, 64'h2);
      check("t5_rises", 64'(rise0 - b_rise), 64'd128);
`ifdef SPI_HOST_BURST_EN
      check("t6_one_frame", 64'(csfall0 - b_fall), 64'd1);
`else
      check("t5_two_frames", 64'(csfall0 - b_fall), 64'd2);
      check("t5_cs_gap", 64'(last_gap0), 64'd3);
`endif
      repeat (4) @(negedge CLK);
      check("t5_idle", 64'(tx_ready0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
